// File: rtl/params_pkg.sv
// -----------------------------------------------------------------------------
// params_pkg
// Shared fetch-stage constants and the fetch controller state encoding.
//   ADDR_W      : PC / address width
//   INSTR_W     : instruction width
//   INSTR_BYTES : sequential PC increment (power of two)
//   RESET_VEC   : first fetch address after reset
//   TRAP_VEC    : fault redirect target (trap build only)
//   fetch_state_t : BOOT, RUN, STALL, FAULT
// -----------------------------------------------------------------------------
package params_pkg;

    localparam int ADDR_W      = 32;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] TRAP_VEC  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Handshake between the fetch controller (master) and the fetch datapath
// (slave).
//   Datapath -> controller : pc_curr, valid, hit, stall_req, br_taken, br_target
//   Controller -> datapath : pc_we, pc_next, hold, flush, fault, fault_addr
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int ADDR_W = params_pkg::ADDR_W
);
    logic [ADDR_W-1:0] pc_curr;
    logic              valid;
    logic              hit;
    logic              stall_req;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              pc_we;
    logic [ADDR_W-1:0] pc_next;
    logic              hold;
    logic              flush;
    logic              fault;
    logic [ADDR_W-1:0] fault_addr;

    modport master (
        input  pc_curr, valid, hit, stall_req, br_taken, br_target,
        output pc_we, pc_next, hold, flush, fault, fault_addr
    );

    modport slave (
        output pc_curr, valid, hit, stall_req, br_taken, br_target,
        input  pc_we, pc_next, hold, flush, fault, fault_addr
    );
endinterface

// File: rtl/fetch_redirect_q.sv
// -----------------------------------------------------------------------------
// fetch_redirect_q
// Single-entry pending-redirect register used while the fetch stage stalls.
//   clk, rst    : clock, synchronous active-high reset
//   capture     : load cap_addr/cap_fault (overwrites any held entry)
//   cap_addr    : redirect target to hold
//   cap_fault   : target is misaligned; releasing it must raise a fault
//   consume     : entry has been issued, drop it
//   clear       : discard entry (fault entry, etc.); wins over capture
//   pend_v, pend_addr, pend_fault : held entry
// -----------------------------------------------------------------------------
module fetch_redirect_q #(
    parameter int ADDR_W = params_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic              cap_fault,
    input  logic              consume,
    input  logic              clear,
    output logic              pend_v,
    output logic [ADDR_W-1:0] pend_addr,
    output logic              pend_fault
);

    logic              pend_v_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic              pend_fault_r;

    // Entry register: clear > capture (latest wins) > consume > hold.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pend_v_r     <= 1'b0;
            pend_addr_r  <= {ADDR_W{1'b0}};
            pend_fault_r <= 1'b0;
        end else if (capture) begin
            pend_v_r     <= 1'b1;
            pend_addr_r  <= cap_addr;
            pend_fault_r <= cap_fault;
        end else if (consume) begin
            pend_v_r     <= 1'b0;
            pend_addr_r  <= pend_addr_r;
            pend_fault_r <= 1'b0;
        end else begin
            pend_v_r     <= pend_v_r;
            pend_addr_r  <= pend_addr_r;
            pend_fault_r <= pend_fault_r;
        end
    end

    assign pend_v     = pend_v_r;
    assign pend_addr  = pend_addr_r;
    assign pend_fault = pend_fault_r;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencing controller. Arbitrates boot vector, branch
// redirects, downstream stalls and sequential advance; flags ROM misses and
// misaligned redirect targets as faults. All outputs are registered.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_ctrl_if.master (datapath status in, PC controls out)
// Build option FETCH_CTRL_TRAP_EN: FAULT lasts one cycle and then redirects
// to TRAP_VEC; without it FAULT is terminal until reset.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int                ADDR_W      = params_pkg::ADDR_W,
    parameter int                INSTR_BYTES = params_pkg::INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_VEC   = params_pkg::RESET_VEC
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    import params_pkg::*;

    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INSTR_BYTES);

    fetch_state_t      state_r, state_nxt_s;

    logic              pc_we_r,      pc_we_s;
    logic [ADDR_W-1:0] pc_next_r,    pc_next_s;
    logic              hold_r,       hold_s;
    logic              flush_r,      flush_s;
    logic              fault_r,      fault_s;
    logic [ADDR_W-1:0] fault_addr_r, fault_addr_s;

    logic              cap_s, consume_s, clear_s;
    logic              pend_v_s, pend_fault_s;
    logic [ADDR_W-1:0] pend_addr_s;

    logic              br_mis_s, run_fault_s;
    logic              eff_v_s, eff_fault_s;
    logic [ADDR_W-1:0] eff_addr_s;

    // Shared decode: a branch seen on the release cycle is newer than the
    // held entry, so it takes its place.
    assign br_mis_s    = bus.br_taken && ((bus.br_target & OFS_MASK) != {ADDR_W{1'b0}});
    assign run_fault_s = (bus.valid && !bus.hit) || br_mis_s;
    assign eff_v_s     = bus.br_taken || pend_v_s;
    assign eff_addr_s  = bus.br_taken ? bus.br_target : pend_addr_s;
    assign eff_fault_s = bus.br_taken ? br_mis_s : pend_fault_s;

    fetch_redirect_q #(.ADDR_W(ADDR_W)) u_redirect_q (
        .clk        (clk),
        .rst        (rst),
        .capture    (cap_s),
        .cap_addr   (bus.br_target),
        .cap_fault  (br_mis_s),
        .consume    (consume_s),
        .clear      (clear_s),
        .pend_v     (pend_v_s),
        .pend_addr  (pend_addr_s),
        .pend_fault (pend_fault_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BOOT:  state_nxt_s = RUN;
            RUN: begin
                if (run_fault_s) begin
                    state_nxt_s = FAULT;
                end else if (bus.stall_req) begin
                    state_nxt_s = STALL;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            STALL: begin
                if (bus.stall_req) begin
                    state_nxt_s = STALL;
                end else if (eff_v_s && eff_fault_s) begin
                    state_nxt_s = FAULT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
`ifdef FETCH_CTRL_TRAP_EN
            FAULT: state_nxt_s = RUN;
`else
            FAULT: state_nxt_s = FAULT;
`endif
            default: state_nxt_s = BOOT;
        endcase
    end

    // Output decode: next values of the output registers plus queue controls.
    always_comb begin
        pc_we_s      = 1'b0;
        pc_next_s    = pc_next_r;
        hold_s       = 1'b0;
        flush_s      = 1'b0;
        fault_s      = 1'b0;
        fault_addr_s = fault_addr_r;
        cap_s        = 1'b0;
        consume_s    = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            BOOT: begin
                pc_we_s   = 1'b1;
                pc_next_s = RESET_VEC;
                flush_s   = 1'b1;
            end
            RUN: begin
                if (run_fault_s) begin
                    hold_s       = 1'b1;
                    flush_s      = 1'b1;
                    fault_s      = 1'b1;
                    fault_addr_s = (bus.valid && !bus.hit) ? bus.pc_curr : bus.br_target;
                    clear_s      = 1'b1;
                end else if (bus.br_taken) begin
                    pc_we_s   = 1'b1;
                    pc_next_s = bus.br_target;
                    flush_s   = 1'b1;
                end else if (bus.stall_req) begin
                    hold_s = 1'b1;
                end else if (bus.valid) begin
                    pc_we_s   = 1'b1;
                    pc_next_s = bus.pc_curr + PC_INC;
                end else begin
                    pc_we_s = 1'b0;
                end
            end
            STALL: begin
                if (bus.stall_req) begin
                    hold_s = 1'b1;
                    cap_s  = bus.br_taken;
                end else if (eff_v_s && eff_fault_s) begin
                    hold_s       = 1'b1;
                    flush_s      = 1'b1;
                    fault_s      = 1'b1;
                    fault_addr_s = eff_addr_s;
                    clear_s      = 1'b1;
                end else if (eff_v_s) begin
                    pc_we_s   = 1'b1;
                    pc_next_s = eff_addr_s;
                    flush_s   = 1'b1;
                    consume_s = 1'b1;
                end else begin
                    hold_s = 1'b0;
                end
            end
            FAULT: begin
`ifdef FETCH_CTRL_TRAP_EN
                pc_we_s   = 1'b1;
                pc_next_s = TRAP_VEC;
                flush_s   = 1'b1;
`else
                hold_s  = 1'b1;
                fault_s = 1'b1;
`endif
            end
            default: begin
                hold_s  = 1'b1;
                flush_s = 1'b1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_we_r      <= 1'b0;
            pc_next_r    <= RESET_VEC;
            hold_r       <= 1'b1;
            flush_r      <= 1'b1;
            fault_r      <= 1'b0;
            fault_addr_r <= {ADDR_W{1'b0}};
        end else begin
            pc_we_r      <= pc_we_s;
            pc_next_r    <= pc_next_s;
            hold_r       <= hold_s;
            flush_r      <= flush_s;
            fault_r      <= fault_s;
            fault_addr_r <= fault_addr_s;
        end
    end

    assign bus.pc_we      = pc_we_r;
    assign bus.pc_next    = pc_next_r;
    assign bus.hold       = hold_r;
    assign bus.flush      = flush_r;
    assign bus.fault      = fault_r;
    assign bus.fault_addr = fault_addr_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed vector bench for fetch_ctrl: a table of per-cycle inputs and the
// outputs expected after that clock edge, followed by a fault-persistence
// sequence. Honours FETCH_CTRL_TRAP_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_ctrl_if #(.ADDR_W(32)) bus ();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        valid;
        logic        hit;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        we;
        logic [31:0] nx;
        logic        hold;
        logic        flush;
        logic        fault;
        logic [31:0] fa;
        logic        pend;
    } vec_t;

    vec_t vec [0:63];
    int   n_vec = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic add(input int r, input logic [31:0] pc, input int v, input int h,
                       input int s, input int b, input logic [31:0] tgt,
                       input int we, input logic [31:0] nx, input int hd,
                       input int fl, input int ft, input logic [31:0] fa, input int pv);
        vec[n_vec].rst   = r[0];
        vec[n_vec].pc    = pc;
        vec[n_vec].valid = v[0];
        vec[n_vec].hit   = h[0];
        vec[n_vec].stall = s[0];
        vec[n_vec].br    = b[0];
        vec[n_vec].tgt   = tgt;
        vec[n_vec].we    = we[0];
        vec[n_vec].nx    = nx;
        vec[n_vec].hold  = hd[0];
        vec[n_vec].flush = fl[0];
        vec[n_vec].fault = ft[0];
        vec[n_vec].fa    = fa;
        vec[n_vec].pend  = pv[0];
        n_vec++;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic v,
                         input logic h, input logic s, input logic b,
                         input logic [31:0] tgt);
        rst           = r;
        bus.pc_curr   = pc;
        bus.valid     = v;
        bus.hit       = h;
        bus.stall_req = s;
        bus.br_taken  = b;
        bus.br_target = tgt;
    endtask

    initial begin
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        //   rst pc           v  h  s  b  tgt     we nx       hd fl ft fa      pend
        add(1, 'h0,          0, 0, 0, 0, 'h0,    0, 'h0,     1, 1, 0, 'h0,    0); // 0 reset
        add(1, 'h0,          0, 0, 0, 0, 'h0,    0, 'h0,     1, 1, 0, 'h0,    0); // 1 reset
        add(0, 'h0,          0, 0, 0, 0, 'h0,    1, 'h0,     0, 1, 0, 'h0,    0); // 2 boot
        add(0, 'h0,          1, 1, 0, 0, 'h0,    1, 'h4,     0, 0, 0, 'h0,    0); // 3 seq
        add(0, 'h4,          1, 1, 0, 0, 'h0,    1, 'h8,     0, 0, 0, 'h0,    0); // 4 seq
        add(0, 'h0,          0, 0, 0, 0, 'h0,    0, 'h8,     0, 0, 0, 'h0,    0); // 5 idle
        add(0, 'h0,          0, 0, 0, 1, 'h40,   1, 'h40,    0, 1, 0, 'h0,    0); // 6 branch
        add(0, 'h0,          0, 0, 0, 1, 'h60,   1, 'h60,    0, 1, 0, 'h0,    0); // 7 b2b branch
        add(0, 'hFFFF_FFFC,  1, 1, 0, 0, 'h0,    1, 'h0,     0, 0, 0, 'h0,    0); // 8 wrap
        add(0, 'h0,          0, 0, 1, 0, 'h0,    0, 'h0,     1, 0, 0, 'h0,    0); // 9 stall
        add(0, 'h0,          0, 0, 1, 1, 'h80,   0, 'h0,     1, 0, 0, 'h0,    1); // 10 capture
        add(0, 'h0,          0, 0, 1, 1, 'h90,   0, 'h0,     1, 0, 0, 'h0,    1); // 11 overwrite
        add(0, 'h0,          0, 0, 0, 0, 'h0,    1, 'h90,    0, 1, 0, 'h0,    0); // 12 release
        add(0, 'h0,          0, 0, 0, 0, 'h0,    0, 'h90,    0, 0, 0, 'h0,    0); // 13 single pulse
        add(0, 'h0,          0, 0, 1, 0, 'h0,    0, 'h90,    1, 0, 0, 'h0,    0); // 14 stall
        add(0, 'h0,          0, 0, 0, 0, 'h0,    0, 'h90,    0, 0, 0, 'h0,    0); // 15 plain release
        add(0, 'h0,          0, 0, 1, 1, 'h100,  1, 'h100,   0, 1, 0, 'h0,    0); // 16 br+stall
        add(0, 'h0,          0, 0, 1, 0, 'h0,    0, 'h100,   1, 0, 0, 'h0,    0); // 17 stall
        add(0, 'h0,          0, 0, 0, 0, 'h0,    0, 'h100,   0, 0, 0, 'h0,    0); // 18 release
        add(0, 'h0,          0, 0, 1, 0, 'h0,    0, 'h100,   1, 0, 0, 'h0,    0); // 19 stall
        add(0, 'h0,          0, 0, 1, 1, 'hA0,   0, 'h100,   1, 0, 0, 'h0,    1); // 20 capture
        add(1, 'h0,          0, 0, 1, 0, 'h0,    0, 'h0,     1, 1, 0, 'h0,    0); // 21 rst mid-stall
        add(0, 'h0,          0, 0, 0, 0, 'h0,    1, 'h0,     0, 1, 0, 'h0,    0); // 22 boot
        add(0, 'h0,          0, 0, 0, 0, 'h0,    0, 'h0,     0, 0, 0, 'h0,    0); // 23 no stale redirect
        add(0, 'h0,          0, 0, 0, 1, 'h42,   0, 'h0,     1, 1, 1, 'h42,   0); // 24 misaligned
`ifdef FETCH_CTRL_TRAP_EN
        add(0, 'h0,          0, 0, 0, 0, 'h0,    1, 'h100,   0, 1, 0, 'h42,   0); // 25 trap
`else
        add(0, 'h0,          0, 0, 0, 0, 'h0,    0, 'h0,     1, 0, 1, 'h42,   0); // 25 sticky
`endif
        add(1, 'h0,          0, 0, 0, 0, 'h0,    0, 'h0,     1, 1, 0, 'h0,    0); // 26 reset
        add(0, 'h0,          0, 0, 0, 0, 'h0,    1, 'h0,     0, 1, 0, 'h0,    0); // 27 boot
        add(0, 'h200,        1, 0, 0, 0, 'h0,    0, 'h0,     1, 1, 1, 'h200,  0); // 28 rom miss
`ifdef FETCH_CTRL_TRAP_EN
        add(0, 'h0,          0, 0, 1, 1, 'h40,   1, 'h100,   0, 1, 0, 'h200,  0); // 29 trap
`else
        add(0, 'h0,          0, 0, 1, 1, 'h40,   0, 'h0,     1, 0, 1, 'h200,  0); // 29 ignored
`endif
        add(1, 'h0,          0, 0, 0, 0, 'h0,    0, 'h0,     1, 1, 0, 'h0,    0); // 30 reset
        add(0, 'h0,          0, 0, 0, 0, 'h0,    1, 'h0,     0, 1, 0, 'h0,    0); // 31 boot
        add(0, 'h0,          0, 0, 1, 0, 'h0,    0, 'h0,     1, 0, 0, 'h0,    0); // 32 stall
        add(0, 'h0,          0, 0, 1, 1, 'h83,   0, 'h0,     1, 0, 0, 'h0,    1); // 33 bad target held
        add(0, 'h0,          0, 0, 0, 0, 'h0,    0, 'h0,     1, 1, 1, 'h83,   0); // 34 fault on release

        for (int i = 0; i < n_vec; i++) begin
            drive(vec[i].rst, vec[i].pc, vec[i].valid, vec[i].hit, vec[i].stall,
                  vec[i].br, vec[i].tgt);
            @(posedge clk);
            #1;
            chk("pc_we",      i, 32'(bus.pc_we),                  32'(vec[i].we));
            chk("pc_next",    i, bus.pc_next,                     vec[i].nx);
            chk("hold",       i, 32'(bus.hold),                   32'(vec[i].hold));
            chk("flush",      i, 32'(bus.flush),                  32'(vec[i].flush));
            chk("fault",      i, 32'(bus.fault),                  32'(vec[i].fault));
            chk("fault_addr", i, bus.fault_addr,                  vec[i].fa);
            chk("pend_v",     i, 32'(dut.u_redirect_q.pend_v),    32'(vec[i].pend));
        end

`ifdef FETCH_CTRL_TRAP_EN
        // One fault cycle, then a single trap redirect pulse.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("trap_we",    100, 32'(bus.pc_we), 32'd1);
        chk("trap_next",  100, bus.pc_next,    32'h100);
        chk("trap_flush", 100, 32'(bus.flush), 32'd1);
        chk("trap_fault", 100, 32'(bus.fault), 32'd0);
        chk("trap_faddr", 100, bus.fault_addr, 32'h83);
        @(posedge clk);
        #1;
        chk("trap_we_pulse",    101, 32'(bus.pc_we), 32'd0);
        chk("trap_flush_pulse", 101, 32'(bus.flush), 32'd0);
`else
        // Fault is terminal: inputs of every kind must not disturb it.
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 32'h10, c[0], 1'b1, c[1], c[2], 32'h40);
            @(posedge clk);
            #1;
            chk("sticky_hold",  100 + c, 32'(bus.hold),  32'd1);
            chk("sticky_fault", 100 + c, 32'(bus.fault), 32'd1);
            chk("sticky_we",    100 + c, 32'(bus.pc_we), 32'd0);
            chk("sticky_flush", 100 + c, 32'(bus.flush), 32'd0);
            chk("sticky_faddr", 100 + c, bus.fault_addr, 32'h83);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
